// File: rtl/pmod_pkg.sv
// ----------------------------------------------------------------------------
// pmod_pkg
// Shared definitions for the Pmod port arbiter slice.
//   state_e      : arbiter FSM state encoding (IDLE / GRANT / TURN)
//   DEF_NUM_REQ  : default number of requesters sharing one header
//   DEF_WIDTH    : default number of Pmod data pins driven
//   DEF_MAX_HOLD : default grant-cycle limit for the timeout build
// ----------------------------------------------------------------------------
package pmod_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_e;

  localparam int DEF_NUM_REQ  = 4;
  localparam int DEF_WIDTH    = 8;
  localparam int DEF_MAX_HOLD = 256;

endpackage

// File: rtl/pmod_port_arbiter_if.sv
// ----------------------------------------------------------------------------
// pmod_port_arbiter_if
// Bundle between the requesters and the Pmod header arbiter.
//   req      : per-requester level request, held until the requester is done
//   data_in  : requester i drives slice [i*WIDTH +: WIDTH]
//   gnt      : one-hot-or-zero registered grant
//   pmod_out : registered pin data to the header
//   pmod_oe  : header output enable, high only while a grant is held
//   busy     : arbiter is not idle
// Modports:
//   master : requester side (drives req/data_in)
//   slave  : arbiter side (drives gnt/pmod_out/pmod_oe/busy)
// ----------------------------------------------------------------------------
interface pmod_port_arbiter_if
  import pmod_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH   = DEF_WIDTH
);

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] data_in;
  logic [NUM_REQ-1:0]       gnt;
  logic [WIDTH-1:0]         pmod_out;
  logic                     pmod_oe;
  logic                     busy;

  modport master (
    output req, data_in,
    input  gnt, pmod_out, pmod_oe, busy
  );

  modport slave (
    input  req, data_in,
    output gnt, pmod_out, pmod_oe, busy
  );

endinterface

// File: rtl/rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin priority select. Returns the first set request
// bit found searching upward from ptr, wrapping NUM_REQ-1 -> 0.
// Ports:
//   req    : request vector
//   ptr    : index with highest priority this round
//   winner : index of the selected requester (0 when none)
//   valid  : at least one request is set
// ----------------------------------------------------------------------------
module rr_pick
  import pmod_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [IW-1:0]      winner,
  output logic               valid
);

  logic [IW-1:0] idx;

  // Walk the offsets from the far end back toward ptr so the closest set bit
  // is the last one written and therefore wins, without needing a break.
  always_comb begin
    // NOTE: every variable written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = IW'((int'(ptr) + i) % NUM_REQ);
      if (req[idx]) begin
        winner = idx;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pmod_port_arbiter.sv
// ----------------------------------------------------------------------------
// pmod_port_arbiter
// Round-robin arbiter letting NUM_REQ requesters share one Pmod header.
// A requester keeps the header while its req stays high; every hand-over
// passes through a single TURN cycle with the pins released, so two owners
// never drive the header back to back.
//
// Parameters:
//   NUM_REQ  : requesters sharing the header (2..8)
//   WIDTH    : Pmod data pins driven
//   MAX_HOLD : grant cycles before a forced release when others wait
//              (only meaningful in the timeout build)
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous, active-high reset
//   bus : pmod_port_arbiter_if.slave (req, data_in, gnt, pmod_out,
//         pmod_oe, busy)
//
// Build option:
//   PMOD_ARB_TIMEOUT_EN : when defined, an owner that has held the header
//   for MAX_HOLD grant cycles while another requester waits is forced
//   through TURN. When undefined the grant lasts until the owner drops req
//   and no hold counter exists.
// ----------------------------------------------------------------------------
module pmod_port_arbiter
  import pmod_pkg::*;
#(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int WIDTH    = DEF_WIDTH,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input logic                clk,
  input logic                rst,
  pmod_port_arbiter_if.slave bus
);

  localparam int IW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_HOLD < 2) begin : g_param_check
    $error("pmod_port_arbiter: NUM_REQ must be 2..8 and MAX_HOLD at least 2");
  end

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic               oe_q, oe_d;
  logic               busy_q, busy_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic [IW-1:0]      ptr_q, ptr_d;

  logic [IW-1:0]      pick_idx;
  logic               pick_valid;
  logic [WIDTH-1:0]   owner_data;
  logic               drop_grant;

`ifdef PMOD_ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD);

  logic [HW-1:0] hold_cnt, hold_d;
  logic          hold_expired;
  logic          others_waiting;

  assign hold_expired   = (hold_cnt == HW'(MAX_HOLD - 1));
  // gnt_q is one-hot on the owner during GRANT, so masking with it leaves
  // exactly the requesters that are being kept waiting.
  assign others_waiting = |(bus.req & ~gnt_q);
`endif

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_pick (
    .req    (bus.req),
    .ptr    (ptr_q),
    .winner (pick_idx),
    .valid  (pick_valid)
  );

  // Constant-index mux of the owner's data slice.
  always_comb begin
    owner_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == IW'(i)) owner_data = bus.data_in[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    out_d      = out_q;
    oe_d       = oe_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    drop_grant = 1'b0;
`ifdef PMOD_ARB_TIMEOUT_EN
    hold_d     = hold_cnt;
`endif

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = GRANT;
          owner_d = pick_idx;
          gnt_d   = NUM_REQ'(1) << pick_idx;
          oe_d    = 1'b1;
          ptr_d   = (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
`ifdef PMOD_ARB_TIMEOUT_EN
          hold_d  = '0;
`endif
        end
      end

      GRANT: begin
        out_d      = owner_data;
        drop_grant = !bus.req[owner_q];
`ifdef PMOD_ARB_TIMEOUT_EN
        // Drop and timeout together still give one TURN: both only feed
        // this single flag.
        if (hold_expired && others_waiting) drop_grant = 1'b1;
        hold_d = hold_expired ? hold_cnt : hold_cnt + 1'b1;
`endif
        if (drop_grant) begin
          state_d = TURN;
          gnt_d   = '0;
          oe_d    = 1'b0;
          out_d   = '0;
        end
      end

      TURN: begin
        // Outputs were already cleared on entry; requests seen now are
        // deliberately ignored so arbitration only happens from IDLE.
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        oe_d    = 1'b0;
        out_d   = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      out_q   <= '0;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      owner_q <= '0;
      ptr_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      state_q <= state_d;
      gnt_q   <= gnt_d;
      out_q   <= out_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef PMOD_ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) hold_cnt <= '0;
    else     hold_cnt <= hold_d;
  end
`endif

  assign bus.gnt      = gnt_q;
  assign bus.pmod_out = out_q;
  assign bus.pmod_oe  = oe_q;
  assign bus.busy     = busy_q;

endmodule

// File: doc/pmod_port_arbiter.md
PMOD_PORT_ARBITER -- requirements
Module: pmod_port_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one Pmod header, range 2..8.
REQ-002 Parameter WIDTH, default 8: Pmod data pins driven.
REQ-003 Parameter MAX_HOLD, default 256: grant cycles before forced release when others wait (timeout build only).
REQ-004 Port clk, input, 1: single clock; all state on rising edge.
REQ-005 Port rst, input, 1: asynchronous, active-high reset.
REQ-006 Port req, input, NUM_REQ: per-requester level request, held until done.
REQ-007 Port data_in, input, NUM_REQ*WIDTH: requester i drives slice [i*WIDTH +: WIDTH].
REQ-008 Port gnt, output, NUM_REQ: one-hot-or-zero registered grant.
REQ-009 Port pmod_out, output, WIDTH: registered pin data to header.
REQ-010 Port pmod_oe, output, 1: header output enable, high only while granted.
REQ-011 Port busy, output, 1: high in any state except IDLE.

Function
REQ-012 FSM states IDLE, GRANT, TURN; all outputs registered.
REQ-013 IDLE: any req high -> next cycle GRANT, gnt one-hot to winner, pmod_oe=1.
REQ-014 Winner: first set req bit searching upward from ptr, wrapping NUM_REQ-1 -> 0.
REQ-015 On each grant ptr <= (winner+1) mod NUM_REQ; ptr unchanged otherwise.
REQ-016 GRANT: pmod_out <= owner's data_in slice every cycle; 1-cycle latency data_in -> pmod_out.
REQ-017 GRANT: req[owner] low -> next cycle TURN.
REQ-018 hold_cnt clears on grant, increments each GRANT cycle, saturates at MAX_HOLD-1.
REQ-019 TURN lasts exactly 1 cycle: gnt=0, pmod_oe=0, pmod_out=0; then IDLE (no same-cycle regrant).
REQ-020 Owner drop and timeout in same cycle -> single TURN; no double handling.
REQ-021 Requests from non-owners during GRANT/TURN are ignored until IDLE; no request latching.
REQ-022 At most one gnt bit high in any cycle; gnt never changes owner without passing TURN.

Reset
REQ-023 rst high: state=IDLE, gnt=0, pmod_out=0, pmod_oe=0, busy=0, ptr=0, hold_cnt=0 immediately, regardless of clk.
REQ-024 rst mid-GRANT drops pmod_oe asynchronously; after release first arbitration uses ptr=0.

Configuration
REQ-025 Macro PMOD_ARB_TIMEOUT_EN defined: in GRANT, hold_cnt==MAX_HOLD-1 and any other req high -> next cycle TURN.
REQ-026 PMOD_ARB_TIMEOUT_EN undefined: grant held until owner drops req; hold_cnt and MAX_HOLD logic absent.

Structure
REQ-027 Shared package pmod_pkg holds FSM state encoding (IDLE=2'd0, GRANT=2'd1, TURN=2'd2) and default WIDTH/NUM_REQ constants.
REQ-028 One sub-module rr_pick: combinational round-robin priority select (req, ptr -> winner index, valid).

Verification
REQ-029 req=4'b0001 at cycle 0 -> gnt=0001, pmod_oe=1 at cycle 1; data_in[7:0]=8'hA5 -> pmod_out=A5 at cycle 2.
REQ-030 req=4'b1111 held, each owner drops after 3 grant cycles -> grant order 0,1,2,3,0 with one TURN cycle (oe=0) between each.
REQ-031 TIMEOUT_EN, MAX_HOLD=8, req0 held, req2 asserted -> TURN after 8th grant cycle, then gnt=0100.
REQ-032 TIMEOUT_EN, req0 alone held 20 cycles -> no release, hold_cnt saturates at 7.
REQ-033 rst pulse mid-GRANT between clock edges -> pmod_oe, gnt, pmod_out zero before next edge; next req=1000 grants 3 via ptr=0 search.
REQ-034 Owner drops req on same cycle as timeout -> exactly one TURN cycle, then normal IDLE arbitration.
